// File: rtl/arith_pkg.sv
// Shared arithmetic-unit definitions: control FSM states and default operand width.
package arith_pkg;

    localparam int DIV_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        DONE = 2'd2
    } div_state_e;

endpackage

// File: rtl/divider_step.sv
// One restoring-division iteration: shift the partial remainder left, trial-subtract
// the divisor, and produce the next quotient bit.
module divider_step
    import arith_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH-1:0] rem_hi,
    input  logic [WIDTH-1:0] rem_lo,
    input  logic [WIDTH-1:0] dvsr,
    output logic [WIDTH-1:0] rem_hi_next,
    output logic [WIDTH-1:0] rem_lo_next,
    output logic             q_bit
);

    logic [WIDTH:0]   upper_s;
    logic [WIDTH-1:0] diff_s;

    // Trial subtract. The shifted upper half keeps its carry bit so a divisor
    // above 2^(WIDTH-1) is compared correctly; the low WIDTH bits of the
    // difference are exact whenever the subtraction does not go negative.
    always_comb begin
        upper_s = {rem_hi, rem_lo[WIDTH-1]};
        diff_s  = upper_s[WIDTH-1:0] - dvsr;
        q_bit   = (upper_s >= {1'b0, dvsr});
        if (q_bit) begin
            rem_hi_next = diff_s;
        end else begin
            rem_hi_next = upper_s[WIDTH-1:0];
        end
        rem_lo_next = {rem_lo[WIDTH-2:0], q_bit};
    end

endmodule

// File: rtl/unsigned_sequential_divider.sv
// Multi-cycle unsigned restoring divider with run/rdy handshake; one quotient bit
// per clock, divide-by-zero short-circuits straight to DONE.
module unsigned_sequential_divider
    import arith_pkg::*;
#(
    parameter  int WIDTH = DIV_WIDTH,
    localparam int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             rdy,
    output logic             div_by_zero
);

    div_state_e       state_r, state_s;
    logic [WIDTH-1:0] rem_hi_r, rem_hi_s;
    logic [WIDTH-1:0] rem_lo_r, rem_lo_s;
    logic [WIDTH-1:0] dvsr_r, dvsr_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic [WIDTH-1:0] quotient_s, remainder_s;
    logic             busy_s, rdy_s, div_by_zero_s;

    logic [WIDTH-1:0] step_hi_s, step_lo_s;
    logic             step_q_s;

    divider_step #(.WIDTH(WIDTH)) u_step (
        .rem_hi      (rem_hi_r),
        .rem_lo      (rem_lo_r),
        .dvsr        (dvsr_r),
        .rem_hi_next (step_hi_s),
        .rem_lo_next (step_lo_s),
        .q_bit       (step_q_s)
    );

    // Next-state and next-output logic; every register holds unless a state changes it.
    always_comb begin
        state_s       = state_r;
        rem_hi_s      = rem_hi_r;
        rem_lo_s      = rem_lo_r;
        dvsr_s        = dvsr_r;
        cnt_s         = cnt_r;
        quotient_s    = quotient;
        remainder_s   = remainder;
        busy_s        = busy;
        rdy_s         = rdy;
        div_by_zero_s = div_by_zero;
        case (state_r)
            IDLE: begin
                rdy_s  = 1'b0;
                busy_s = 1'b0;
                if (run) begin
                    if (divisor != {WIDTH{1'b0}}) begin
                        rem_hi_s      = {WIDTH{1'b0}};
                        rem_lo_s      = dividend;
                        dvsr_s        = divisor;
                        cnt_s         = {CNT_W{1'b0}};
                        div_by_zero_s = 1'b0;
                        busy_s        = 1'b1;
                        state_s       = ITER;
                    end else begin
                        quotient_s    = {WIDTH{1'b1}};
                        remainder_s   = dividend;
                        div_by_zero_s = 1'b1;
                        rdy_s         = 1'b1;
                        state_s       = DONE;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            ITER: begin
                rem_hi_s = step_hi_s;
                rem_lo_s = step_lo_s;
                cnt_s    = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                if (cnt_r == CNT_W'(WIDTH - 1)) begin
                    quotient_s  = step_lo_s;
                    remainder_s = step_hi_s;
                    busy_s      = 1'b0;
                    rdy_s       = 1'b1;
                    state_s     = DONE;
                end else begin
                    busy_s = 1'b1;
                end
            end
            DONE: begin
                busy_s = 1'b0;
                if (run) begin
                    rdy_s = 1'b1;
                end else begin
                    rdy_s   = 1'b0;
                    state_s = IDLE;
                end
            end
            default: begin
                busy_s  = 1'b0;
                rdy_s   = 1'b0;
                state_s = IDLE;
            end
        endcase
    end

    // State, datapath and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= IDLE;
            rem_hi_r    <= {WIDTH{1'b0}};
            rem_lo_r    <= {WIDTH{1'b0}};
            dvsr_r      <= {WIDTH{1'b0}};
            cnt_r       <= {CNT_W{1'b0}};
            quotient    <= {WIDTH{1'b0}};
            remainder   <= {WIDTH{1'b0}};
            busy        <= 1'b0;
            rdy         <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            state_r     <= state_s;
            rem_hi_r    <= rem_hi_s;
            rem_lo_r    <= rem_lo_s;
            dvsr_r      <= dvsr_s;
            cnt_r       <= cnt_s;
            quotient    <= quotient_s;
            remainder   <= remainder_s;
            busy        <= busy_s;
            rdy         <= rdy_s;
            div_by_zero <= div_by_zero_s;
        end
    end

endmodule

// File: tb/tb_unsigned_sequential_divider.sv
// Directed and small randomized self-checking bench for the 32-bit sequential divider.
module tb_unsigned_sequential_divider;

    logic        clk;
    logic        rst;
    logic        run;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        busy;
    logic        rdy;
    logic        div_by_zero;

    int tests;
    int fails;

    unsigned_sequential_divider #(.WIDTH(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .run         (run),
        .dividend    (dividend),
        .divisor     (divisor),
        .quotient    (quotient),
        .remainder   (remainder),
        .busy        (busy),
        .rdy         (rdy),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Launch one division, count edges (accept edge = 1) until rdy, check results
    // against the arithmetic golden model. With hold=0, run drops after the accept
    // edge and the operands are scrambled to show they are ignored.
    task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input bit hold);
        int          n;
        bit          seen;
        logic [31:0] exp_q;
        logic [31:0] exp_r;
        int          exp_lat;
        exp_q   = (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
        exp_r   = (b == 32'd0) ? a : a % b;
        exp_lat = (b == 32'd0) ? 1 : 33;
        @(negedge clk);
        dividend = a;
        divisor  = b;
        run      = 1'b1;
        @(posedge clk);
        #1;
        n    = 1;
        seen = rdy;
        check({tag, "_busy_after_accept"}, {31'd0, busy}, {31'd0, (b != 32'd0)});
        if (!hold) begin
            @(negedge clk);
            run      = 1'b0;
            dividend = $urandom;
            divisor  = $urandom;
        end
        while (!seen && n < 40) begin
            @(posedge clk);
            #1;
            n++;
            seen = rdy;
        end
        check({tag, "_latency"}, n, exp_lat);
        check({tag, "_quotient"}, quotient, exp_q);
        check({tag, "_remainder"}, remainder, exp_r);
        check({tag, "_dbz"}, {31'd0, div_by_zero}, {31'd0, (b == 32'd0)});
        check({tag, "_busy_done"}, {31'd0, busy}, 32'd0);
        if (!hold) begin
            @(posedge clk);
            #1;
            check({tag, "_rdy_idle"}, {31'd0, rdy}, 32'd0);
            check({tag, "_q_hold_idle"}, quotient, exp_q);
        end
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        tests    = 0;
        fails    = 0;
        rst      = 1'b0;
        run      = 1'b0;
        dividend = 32'd0;
        divisor  = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_quotient", quotient, 32'd0);
        check("reset_remainder", remainder, 32'd0);
        check("reset_flags", {29'd0, busy, rdy, div_by_zero}, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        do_op("d100_7", 32'd100, 32'd7, 1'b0);
        check("d100_7_q_const", quotient, 32'd14);
        check("d100_7_r_const", remainder, 32'd2);

        do_op("dmax_1", 32'hFFFF_FFFF, 32'd1, 1'b0);
        check("dmax_1_q_const", quotient, 32'hFFFF_FFFF);
        check("dmax_1_r_const", remainder, 32'd0);

        do_op("d3_10", 32'd3, 32'd10, 1'b0);
        check("d3_10_q_const", quotient, 32'd0);
        check("d3_10_r_const", remainder, 32'd3);

        do_op("d5_0", 32'd5, 32'd0, 1'b0);
        check("d5_0_q_const", quotient, 32'hFFFF_FFFF);
        check("d5_0_r_const", remainder, 32'd5);

        do_op("dbig_dvsr", 32'hFFFF_FFFE, 32'hFFFF_FFFF, 1'b0);
        check("dbig_dvsr_r_const", remainder, 32'hFFFF_FFFE);
        do_op("dhigh_dvsr", 32'hF000_0000, 32'h8000_0001, 1'b0);
        check("dhigh_dvsr_q_const", quotient, 32'd1);
        check("dhigh_dvsr_r_const", remainder, 32'h6FFF_FFFF);

        // run held high through DONE: rdy stays, no restart
        do_op("dhold", 32'd77, 32'd5, 1'b1);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check("hold_rdy", {31'd0, rdy}, 32'd1);
            check("hold_busy", {31'd0, busy}, 32'd0);
            check("hold_q", quotient, 32'd15);
        end
        @(negedge clk);
        run = 1'b0;
        @(posedge clk);
        #1;
        check("hold_release_rdy", {31'd0, rdy}, 32'd0);
        do_op("d8000_10", 32'h8000_0000, 32'h10, 1'b0);
        check("d8000_10_q_const", quotient, 32'h0800_0000);
        check("d8000_10_r_const", remainder, 32'd0);

        // asynchronous reset between edges during iteration 12
        @(negedge clk);
        dividend = 32'h1234_5678;
        divisor  = 32'd3;
        run      = 1'b1;
        @(posedge clk);
        @(negedge clk);
        run = 1'b0;
        repeat (12) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("midreset_quotient", quotient, 32'd0);
        check("midreset_remainder", remainder, 32'd0);
        check("midreset_flags", {29'd0, busy, rdy, div_by_zero}, 32'd0);
        #4;
        rst = 1'b1;
        do_op("d1000_33", 32'd1000, 32'd33, 1'b0);
        check("d1000_33_q_const", quotient, 32'd30);
        check("d1000_33_r_const", remainder, 32'd10);

        for (int k = 0; k < 150; k++) begin
            ra = $urandom;
            case ($urandom_range(0, 3))
                0:       rb = 32'd0;
                1:       rb = $urandom_range(1, 255);
                2:       rb = $urandom | 32'h8000_0000;
                default: rb = $urandom;
            endcase
            do_op("rand", ra, rb, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
